// File: rtl/fp32_mul_pipe.sv
// fp32_mul_pipe: pipelined FP32 multiplier (truncate, flush-to-zero) with valid/ready handshakes
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   operand handshake for a, b
//   out_valid/out_ready result handshake for result, flags {nan, overflow, underflow}
module fp32_mul_pipe (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic [2:0]  flags
);
  logic        stall;
  logic        v0_q, v1_q, v2_q, ov_q;
  logic [31:0] a_q, b_q, res_q, res_d;
  logic [2:0]  flg_q, flg_d;
  logic        za, zb, ia, ib, na, nb;
  logic        sign1_q, nan1_q, inf1_q, zero1_q;
  logic        sign2_q, nan2_q, inf2_q, zero2_q;
  logic [9:0]  e1_d, e1_q, e2_d, e2_q;
  logic [24:0] p_d, p_q;
  logic [22:0] mant_d, mant_q;
  logic        ovf, unf;
  assign stall    = ov_q && !out_ready;
  assign in_ready = !stall;
  assign out_valid = ov_q;
  assign result    = res_q;
  assign flags     = flg_q;
  assign za = a_q[30:23] == 8'd0;
  assign zb = b_q[30:23] == 8'd0;
  assign ia = &a_q[30:23] && a_q[22:0] == 23'd0;
  assign ib = &b_q[30:23] && b_q[22:0] == 23'd0;
  assign na = &a_q[30:23] && |a_q[22:0];
  assign nb = &b_q[30:23] && |b_q[22:0];
  assign e1_d = {2'b0, a_q[30:23]} + {2'b0, b_q[30:23]} - 10'd127;
  // only product bits 47..23 survive truncating normalization
  assign p_d = 25'((48'({1'b1, a_q[22:0]}) * 48'({1'b1, b_q[22:0]})) >> 23);
  assign mant_d = p_q[24] ? p_q[23:1] : p_q[22:0];
  assign e2_d   = e1_q + {9'd0, p_q[24]};
  assign ovf = $signed(e2_q) >= 10'sd255;
  assign unf = $signed(e2_q) <= 10'sd0;
  assign res_d = nan2_q  ? 32'h7FC00000 :
                 inf2_q  ? {sign2_q, 8'hFF, 23'd0} :
                 zero2_q ? {sign2_q, 31'd0} :
                 ovf     ? {sign2_q, 8'hFF, 23'd0} :
                 unf     ? {sign2_q, 31'd0} :
                           {sign2_q, e2_q[7:0], mant_q};
  assign flg_d = nan2_q ? 3'b100 : (inf2_q || zero2_q) ? 3'b000 :
                 ovf ? 3'b010 : unf ? 3'b001 : 3'b000;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0; v1_q <= 1'b0; v2_q <= 1'b0; ov_q <= 1'b0;
      a_q <= '0; b_q <= '0;
      sign1_q <= 1'b0; nan1_q <= 1'b0; inf1_q <= 1'b0; zero1_q <= 1'b0;
      e1_q <= '0; p_q <= '0;
      sign2_q <= 1'b0; nan2_q <= 1'b0; inf2_q <= 1'b0; zero2_q <= 1'b0;
      e2_q <= '0; mant_q <= '0;
      res_q <= '0; flg_q <= '0;
    end else if (!stall) begin
      v0_q    <= in_valid;
      a_q     <= a;
      b_q     <= b;
      v1_q    <= v0_q;
      sign1_q <= a_q[31] ^ b_q[31];
      nan1_q  <= na || nb || (ia && zb) || (ib && za);
      inf1_q  <= ia || ib;
      zero1_q <= za || zb;
      e1_q    <= e1_d;
      p_q     <= p_d;
      v2_q    <= v1_q;
      sign2_q <= sign1_q;
      nan2_q  <= nan1_q;
      inf2_q  <= inf1_q;
      zero2_q <= zero1_q;
      e2_q    <= e2_d;
      mant_q  <= mant_d;
      ov_q    <= v2_q;
      // bubbles leave result/flags at zero
      res_q   <= v2_q ? res_d : 32'd0;
      flg_q   <= v2_q ? flg_d : 3'd0;
    end
  end
endmodule

// File: tb/tb_fp32_mul_pipe.sv
// tb_fp32_mul_pipe: directed self-checking bench for fp32_mul_pipe
module tb_fp32_mul_pipe;
  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, result;
  logic [2:0]  flags;
  int          n_assert = 0;
  int          n_fail = 0;
  logic [31:0] in_t [8];
  logic [31:0] exp_t [8];
  localparam logic [31:0] TWO = 32'h40000000;

  fp32_mul_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic single(input string tag, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [2:0] ef);
    a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; a = '0; b = '0;
    tick();
    tick();
    chk({tag, "_early"}, {31'd0, out_valid}, 32'd0);
    tick();
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_res"}, result, er);
    chk({tag, "_flags"}, {29'd0, flags}, {29'd0, ef});
    tick();
  endtask

  // drives n pairs in_t[base+k] x 2.0, consumer stalls in windows lo..hi
  task automatic stream(input string tag, input int base, input int n, input int lo, input int hi);
    int p = 0;
    int q = 0;
    int w = 0;
    while (q < n && w < 60) begin
      in_valid  = p < n;
      a         = (p < n) ? in_t[base + p] : 32'd0;
      b         = TWO;
      out_ready = !(w >= lo && w <= hi);
      #2;
      if (w >= lo && w <= hi) begin
        chk($sformatf("%s_stall_ready_w%0d", tag, w), {31'd0, in_ready}, 32'd0);
        chk($sformatf("%s_stall_hold_w%0d", tag, w), result, exp_t[base]);
      end else
        chk($sformatf("%s_ready_w%0d", tag, w), {31'd0, in_ready}, 32'd1);
      if (out_valid && out_ready) begin
        chk($sformatf("%s_res%0d", tag, q), result, exp_t[base + q]);
        chk($sformatf("%s_flags%0d", tag, q), {29'd0, flags}, 32'd0);
        if (lo < 0) chk($sformatf("%s_timing%0d", tag, q), w, q + 4);
        q++;
      end
      if (in_valid && in_ready) p++;
      w++;
      tick();
    end
    in_valid = 1'b0;
    chk({tag, "_count"}, q, n);
    chk({tag, "_nodup"}, {31'd0, out_valid}, 32'd0);
    tick();
  endtask

  initial begin
    in_t  = '{32'h00000000, 32'h3F800000, 32'h40000000, 32'h40400000,
              32'h40800000, 32'h40A00000, 32'h40C00000, 32'h40E00000};
    exp_t = '{32'h00000000, 32'h40000000, 32'h40800000, 32'h40C00000,
              32'h41000000, 32'h41200000, 32'h41400000, 32'h41600000};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0;
    #1;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_res", result, 32'd0);
    chk("rst_flags", {29'd0, flags}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    single("mul_1p5x2", 32'h3FC00000, 32'h40000000, 32'h40400000, 3'b000);
    single("mul_m2x3", 32'hC0000000, 32'h40400000, 32'hC0C00000, 3'b000);
    single("inf_x_zero", 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b100);
    single("overflow", 32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 3'b010);
    single("underflow", 32'h00800000, 32'h3F000000, 32'h00000000, 3'b001);
    single("denorm", 32'h00000001, 32'h3F800000, 32'h00000000, 3'b000);
    single("nan_in", 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b100);
    single("neg_inf", 32'hFF800000, 32'h40000000, 32'hFF800000, 3'b000);

    stream("stream", 0, 8, -1, -1);
    stream("bp", 1, 5, 4, 7);

    out_ready = 1'b1;
    a = in_t[3]; b = TWO; in_valid = 1'b1;
    tick();
    a = in_t[5];
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_res", result, 32'h40C00000);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_res", result, 32'd0);
    chk("arst_flags", {29'd0, flags}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    #1 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("no_stale%0d", i), {31'd0, out_valid}, 32'd0);
      tick();
    end
    single("post_rst", 32'h3F800000, 32'h3F800000, 32'h3F800000, 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
